// File: rtl/vtseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vtseq_pkg
// Purpose  : Shared types and constants for the VT-sensor SPI sequencer.
// Revision : 1.0
// ============================================================================
package vtseq_pkg;

    localparam int FRAME_BITS_DEFAULT = 64;

    // Command-word bit positions understood by the sensor top.
    localparam int CMD_WIN32_BIT = 59;
    localparam int CMD_R1_EN_BIT = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } vtseq_state_e;

endpackage
`default_nettype wire

// File: rtl/vtseq_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : vtseq_spi_shifter
// Purpose  : SCLK half-period timing, bit counting and MOSI/MISO shift registers.
// Revision : 1.0
// ============================================================================
module vtseq_spi_shifter
#(
    parameter int FRAME_BITS = 64,
    parameter int CLK_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic                  clear,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  last_edge,
    output logic [FRAME_BITS-1:0] rx_word
);

    localparam int BIT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [HALF_W-1:0]     r_half_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;
    logic                  r_sclk;
    logic                  w_half_end;
    logic                  w_last_bit;

    assign w_half_end = (r_half_cnt == HALF_W'(CLK_DIV - 1));
    assign w_last_bit = (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign last_edge  = run && r_sclk && w_half_end && w_last_bit;

    // MOSI is the top of the transmit register; clearing the register parks it low.
    assign mosi    = r_tx[FRAME_BITS-1];
    assign sclk    = r_sclk;
    assign rx_word = r_rx;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
        end else if (load) begin
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= load_word;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
        end else if (run) begin
            if (!w_half_end) begin
                r_half_cnt <= r_half_cnt + HALF_W'(1);
            end else begin
                r_half_cnt <= '0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[FRAME_BITS-2:0], miso};
                end else begin
                    r_sclk <= 1'b0;
                    if (w_last_bit) begin
                        r_tx <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        r_tx      <= {r_tx[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vt_sensor_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vt_sensor_spi_sequencer
// Purpose  : SPI master running N framed measurement sessions of the VT sensor
//            and returning each readback over valid/ready.
//            Optional macro VTSEQ_DUMMY_RO_EN adds the enable_dummy_ro output.
// Revision : 1.0
// ============================================================================
module vt_sensor_spi_sequencer
    import vtseq_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int CLK_DIV    = 1,
    parameter int SETUP_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int GAP_CYC    = 15,
    parameter int SESS_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] cmd_word,
    input  logic [SESS_W-1:0]     n_sessions,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [SESS_W-1:0]     sess_idx,
    output logic                  spi_cs,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun
`ifdef VTSEQ_DUMMY_RO_EN
    ,
    output logic                  enable_dummy_ro
`endif
);

    localparam int CNT_W = 16;

    vtseq_state_e          r_state;
    vtseq_state_e          w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [FRAME_BITS-1:0] r_cmd;
    logic [SESS_W-1:0]     r_n_sess;
    logic [SESS_W-1:0]     r_sess_idx;
    logic [FRAME_BITS-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_overrun;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_frame_done;
    logic                  w_last_sess;
    logic                  w_shift_done;
    logic [FRAME_BITS-1:0] w_load_word;
    logic [FRAME_BITS-1:0] w_rx_word;
    logic                  w_busy;
    logic                  w_cs;
    logic                  w_done;

    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_load       = (r_state != ST_SETUP) && (w_next == ST_SETUP);
    assign w_clear      = abort && (r_state != ST_IDLE);
    assign w_last_sess  = (r_sess_idx == r_n_sess - SESS_W'(1));
    assign w_frame_done = (r_state == ST_HOLD) && (r_cnt == CNT_W'(HOLD_CYC - 1)) && !abort;
    assign w_load_word  = (r_state == ST_IDLE) ? cmd_word : r_cmd;

    vtseq_spi_shifter #(
        .FRAME_BITS (FRAME_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .run       (r_state == ST_SHIFT),
        .clear     (w_clear),
        .load_word (w_load_word),
        .miso      (spi_miso),
        .sclk      (spi_clk),
        .mosi      (spi_mosi),
        .last_edge (w_shift_done),
        .rx_word   (w_rx_word)
    );

    // State register; r_cnt times the current state and restarts on every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (n_sessions == '0) ? ST_FINISH : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_shift_done) begin
                    w_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                    w_next = w_last_sess ? ST_FINISH : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_next = ST_SETUP;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        w_busy = 1'b1;
        w_cs   = 1'b1;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE:                     w_busy = 1'b0;
            ST_SETUP, ST_SHIFT, ST_HOLD: w_cs   = 1'b0;
            ST_FINISH: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = w_busy;
    assign done   = w_done;
    assign spi_cs = w_cs;

    // A frame landing on an accept cycle replaces the accepted word without an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= '0;
            r_n_sess   <= '0;
            r_sess_idx <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd      <= cmd_word;
                r_n_sess   <= n_sessions;
                r_sess_idx <= '0;
                r_overrun  <= 1'b0;
            end else if ((r_state == ST_GAP) && (w_next == ST_SETUP)) begin
                r_sess_idx <= r_sess_idx + SESS_W'(1);
            end
            if (w_frame_done) begin
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign sess_idx   = r_sess_idx;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign rx_overrun = r_overrun;

`ifdef VTSEQ_DUMMY_RO_EN
    assign enable_dummy_ro = w_busy && w_cs;
`else
    // Dummy ring-oscillator load control is not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_vt_sensor_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vt_sensor_spi_sequencer
// Purpose  : Directed + randomized bench with a frame-level SPI slave and host model.
// Revision : 1.0
// ============================================================================
module tb_vt_sensor_spi_sequencer;
    import vtseq_pkg::*;

    localparam int FB       = 64;
    localparam int SETUP    = 2;
    localparam int DIV      = 1;
    localparam int HOLD     = 1;
    localparam int GAP      = 15;
    localparam int CS_LOW   = SETUP + 2 * DIV * FB + HOLD;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          spi_miso   = 1'b0;
    logic          rx_ready   = 1'b0;
    logic [63:0]   cmd_word   = '0;
    logic [3:0]    n_sessions = '0;
    logic          busy, done, spi_cs, spi_clk, spi_mosi, rx_valid, rx_overrun;
    logic [3:0]    sess_idx;
    logic [63:0]   rx_data;
`ifdef VTSEQ_DUMMY_RO_EN
    logic          enable_dummy_ro;
`endif

    vt_sensor_spi_sequencer #(
        .FRAME_BITS (FB), .CLK_DIV (DIV), .SETUP_CYC (SETUP),
        .HOLD_CYC (HOLD), .GAP_CYC (GAP), .SESS_W (4)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .cmd_word (cmd_word),
        .n_sessions (n_sessions), .abort (abort), .busy (busy), .done (done),
        .sess_idx (sess_idx), .spi_cs (spi_cs), .spi_clk (spi_clk),
        .spi_mosi (spi_mosi), .spi_miso (spi_miso), .rx_data (rx_data),
        .rx_valid (rx_valid), .rx_ready (rx_ready), .rx_overrun (rx_overrun)
`ifdef VTSEQ_DUMMY_RO_EN
        , .enable_dummy_ro (enable_dummy_ro)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_active = 0, m_valid = 0, m_overrun = 0, use_fixed = 0, just_rose = 0;
    logic [63:0] m_data = '0, exp_cmd = '0, cur_pat = '0, last_pat = '0, mosi_bits = '0;
    logic [63:0] fixed_pat = 64'hA5A5_0F0F_1234_5678;
    int          frame_idx = 0, n_exp = 0, run_frames = 0, rises = 0, cs_low_len = 0;
    int          gap_len = 0, done_seen = 0, valid_rises = 0, ready_mode = 0, trig_frame = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture inputs seen at the edge, observe at the negedge, update model.
    task automatic step();
        logic        s_start, s_abort, s_rst, s_ready, was_active, frame_end, exp_done;
        logic [63:0] s_cmd;
        logic [3:0]  s_n;
        s_start = start; s_abort = abort; s_rst = rst; s_ready = rx_ready;
        s_cmd = cmd_word; s_n = n_sessions; was_active = m_active;
        @(negedge clk);
        exp_done = 1'b0; frame_end = 1'b0; just_rose = 1'b0;
        if (s_rst) begin
            m_active = 0; m_valid = 0; m_overrun = 0; m_data = '0;
        end else if (s_start && !was_active) begin
            m_active = 1; m_overrun = 0; frame_idx = 0; n_exp = int'(s_n); exp_cmd = s_cmd;
            if (s_n == 4'd0) begin
                m_active = 0; exp_done = 1'b1;
            end
        end else if (s_abort && was_active) begin
            m_active = 0;
        end

        if (!spi_cs && prev_cs) begin
            chk("cs_fall_only_in_run", 64'(m_active), 64'd1);
            if (frame_idx > 0) chk("gap_len", 64'(gap_len), 64'(GAP));
            chk("sess_idx_at_setup", 64'(sess_idx), 64'(frame_idx));
            chk("mosi_first_bit", 64'(spi_mosi), 64'(exp_cmd[63]));
            cs_low_len = 0; rises = 0; mosi_bits = '0;
            cur_pat = use_fixed ? fixed_pat : {$urandom, $urandom};
        end
        if (!spi_cs) cs_low_len++;
        if (spi_clk && !prev_sclk) begin
            rises++; just_rose = 1'b1;
            mosi_bits = {mosi_bits[62:0], spi_mosi};
        end
        if (spi_mosi !== prev_mosi) chk("mosi_moves_sclk_low", 64'(spi_clk), 64'd0);
        if (spi_cs && !prev_cs && !s_rst && !(s_abort && was_active)) begin
            frame_end = 1'b1;
            chk("cs_low_cycles", 64'(cs_low_len), 64'(CS_LOW));
            chk("sclk_rises", 64'(rises), 64'(FB));
            chk("mosi_bits", mosi_bits, exp_cmd);
            chk("rx_data_frame", rx_data, cur_pat);
            chk("sess_idx_frame", 64'(sess_idx), 64'(frame_idx));
            if (frame_idx == n_exp - 1) begin
                exp_done = 1'b1; m_active = 0;
            end
            frame_idx++; run_frames++; gap_len = 0; last_pat = cur_pat;
        end
        if (spi_cs) gap_len++;

        if (!s_rst) begin
            if (frame_end) begin
                if (m_valid && !s_ready) m_overrun = 1;
                m_valid = 1; m_data = cur_pat;
            end else if (m_valid && s_ready) begin
                m_valid = 0;
            end
        end

        chk("busy", 64'(busy), 64'(m_active));
        chk("done", 64'(done), 64'(exp_done));
        chk("rx_valid", 64'(rx_valid), 64'(m_valid));
        chk("rx_overrun", 64'(rx_overrun), 64'(m_overrun));
        chk("rx_data", rx_data, m_data);
        if (!m_active) begin
            chk("idle_cs_high", 64'(spi_cs), 64'd1);
            chk("idle_sclk_low", 64'(spi_clk), 64'd0);
            chk("idle_mosi_low", 64'(spi_mosi), 64'd0);
        end
`ifdef VTSEQ_DUMMY_RO_EN
        chk("dummy_ro", 64'(enable_dummy_ro), 64'(m_active && spi_cs));
`endif
        if (done) done_seen++;
        if (rx_valid && !prev_valid) valid_rises++;
        prev_cs = spi_cs; prev_sclk = spi_clk; prev_mosi = spi_mosi; prev_valid = rx_valid;

        spi_miso = (!spi_cs && rises < FB) ? cur_pat[63 - rises] : 1'b0;
        case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic start_run(input logic [63:0] c, input logic [3:0] n);
        cmd_word = c; n_sessions = n; start = 1'b1;
        run_frames = 0; done_seen = 0; valid_rises = 0;
        step();
        start = 1'b0;
    endtask

    // Runs until the model goes idle; the *_rise arguments inject events at that SCLK rise.
    task automatic run_to_idle(input int abort_rise, input int rst_rise, input int bstart_rise);
        int budget;
        budget = 0;
        while (m_active && budget < 6000) begin
            if (just_rose && run_frames == trig_frame) begin
                if (rises == abort_rise) abort = 1'b1;
                if (rises == rst_rise) rst = 1'b1;
                if (rises == bstart_rise) begin
                    start = 1'b1; cmd_word = ~cmd_word; n_sessions = 4'hF;
                end
            end
            step();
            abort = 1'b0; rst = 1'b0; start = 1'b0;
            budget++;
        end
        chk("run_within_budget", 64'(m_active), 64'd0);
    endtask

    initial begin
        // Reset state
        idle(3);
        rst = 1'b0;
        chk("reset_sess_idx", 64'(sess_idx), 64'd0);
        idle(2);

        // Single session, fixed readback, win32 + R1 enable command
        ready_mode = 1; use_fixed = 1;
        start_run((64'd1 << CMD_WIN32_BIT) | (64'd1 << CMD_R1_EN_BIT), 4'd1);
        run_to_idle(0, 0, 0);
        chk("t1_frames", 64'(run_frames), 64'd1);
        chk("t1_done_count", 64'(done_seen), 64'd1);
        idle(3);

        // Three sessions, host always ready, a START attempted mid-frame
        use_fixed = 0;
        start_run({$urandom, $urandom}, 4'd3);
        run_to_idle(0, 0, 10);
        chk("t2_frames", 64'(run_frames), 64'd3);
        chk("t2_valid_pulses", 64'(valid_rises), 64'd3);
        chk("t2_done_count", 64'(done_seen), 64'd1);
        idle(3);

        // Two sessions with host stalled -> overrun
        ready_mode = 0;
        start_run({$urandom, $urandom}, 4'd2);
        run_to_idle(0, 0, 0);
        chk("t3_overrun", 64'(rx_overrun), 64'd1);
        chk("t3_rx_last", rx_data, last_pat);
        idle(3);

        // ABORT in IDLE is ignored; START+ABORT together: START wins and clears overrun
        abort = 1'b1; step(); abort = 1'b0;
        ready_mode = 2;
        cmd_word = {$urandom, $urandom}; n_sessions = 4'd1;
        start = 1'b1; abort = 1'b1; run_frames = 0; done_seen = 0;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t3_overrun_cleared", 64'(rx_overrun), 64'd0);
        run_to_idle(0, 0, 0);
        chk("t3b_frames", 64'(run_frames), 64'd1);
        idle(3);

        // Abort at the 20th SCLK rise
        start_run({$urandom, $urandom}, 4'd2);
        run_to_idle(20, 0, 0);
        chk("t4_abort_cs", 64'(spi_cs), 64'd1);
        chk("t4_abort_sclk", 64'(spi_clk), 64'd0);
        chk("t4_no_frames", 64'(run_frames), 64'd0);
        idle(4);
        chk("t4_no_done", 64'(done_seen), 64'd0);

        // Zero sessions
        start_run({$urandom, $urandom}, 4'd0);
        idle(4);
        chk("t5_done_count", 64'(done_seen), 64'd1);
        chk("t5_no_frames", 64'(run_frames), 64'd0);

        // Randomized runs
        for (int r = 0; r < 3; r++) begin
            logic [3:0] n;
            n = 4'($urandom_range(1, 3));
            start_run({$urandom, $urandom}, n);
            run_to_idle(0, 0, 0);
            chk("rand_frames", 64'(run_frames), 64'(n));
            idle(3);
        end

        // Reset mid-SHIFT of the second frame with unaccepted data pending
        ready_mode = 0; trig_frame = 1;
        start_run({$urandom, $urandom}, 4'd3);
        run_to_idle(0, 30, 0);
        chk("t6_rx_valid", 64'(rx_valid), 64'd0);
        chk("t6_rx_data", rx_data, 64'd0);
        chk("t6_sess_idx", 64'(sess_idx), 64'd0);
        chk("t6_cs", 64'(spi_cs), 64'd1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
